// File: rtl/mc_control_ws_pkg.sv
// Shared types and encodings for the multicycle control unit: state enum,
// instruction field codes and datapath mux select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_WB_MEM = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_EXEC_I = 4'd8,
    S_WB_I   = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  localparam logic [1:0] MTR_ALU_RD = 2'b00;
  localparam logic [1:0] MTR_MDR_RT = 2'b01;
  localparam logic [1:0] MTR_ALU_RT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_ws_if.sv
// Control bus between the multicycle controller and the datapath/memories.
interface mc_control_ws_if #(
  parameter int unsigned OP_W      = 6,
  parameter int unsigned ALU_SEL_W = 4,
  parameter int unsigned CNT_W     = 32
);
  logic [OP_W-1:0]      opcode;
  logic [OP_W-1:0]      funct;
  logic                 stall;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 imem_req;
  logic                 dmem_req;
  logic                 PCWrite;
  logic                 PCWriteCond;
  logic                 IRWrite;
  logic                 DMEMWrite;
  logic                 RegWrite;
  logic                 ALUSrcA;
  logic                 RegReadSel;
  logic [1:0]           MemtoReg;
  logic [1:0]           ALUSrcB;
  logic [1:0]           PCSource;
  logic [ALU_SEL_W-1:0] ALUSel;
  logic [3:0]           state_dbg;
  logic                 retire;
  logic [CNT_W-1:0]     instr_count;
  logic                 illegal;
  logic                 timeout;

  modport master (
    input  opcode, funct, stall, imem_ready, dmem_ready,
    output imem_req, dmem_req, PCWrite, PCWriteCond, IRWrite, DMEMWrite,
           RegWrite, ALUSrcA, RegReadSel, MemtoReg, ALUSrcB, PCSource,
           ALUSel, state_dbg, retire, instr_count, illegal, timeout
  );

  modport slave (
    output opcode, funct, stall, imem_ready, dmem_ready,
    input  imem_req, dmem_req, PCWrite, PCWriteCond, IRWrite, DMEMWrite,
           RegWrite, ALUSrcA, RegReadSel, MemtoReg, ALUSrcB, PCSource,
           ALUSel, state_dbg, retire, instr_count, illegal, timeout
  );
endinterface

// File: rtl/mc_control_ws_alu_decode.sv
// R-type funct field to ALU operation, flagging unsupported functs.
module mc_alu_decode import mc_ctrl_pkg::*; #(
  parameter int unsigned OP_W      = 6,
  parameter int unsigned ALU_SEL_W = 4
) (
  input  logic [OP_W-1:0]      i_funct,
  output logic [ALU_SEL_W-1:0] o_alu_sel,
  output logic                 o_illegal
);

  always_comb begin
    o_alu_sel = '0;
    o_illegal = 1'b0;
    case (i_funct)
      OP_W'(FN_ADD): o_alu_sel = ALU_SEL_W'(ALU_ADD);
      OP_W'(FN_SUB): o_alu_sel = ALU_SEL_W'(ALU_SUB);
      OP_W'(FN_AND): o_alu_sel = ALU_SEL_W'(ALU_AND);
      OP_W'(FN_OR):  o_alu_sel = ALU_SEL_W'(ALU_OR);
      OP_W'(FN_SLT): o_alu_sel = ALU_SEL_W'(ALU_SLT);
      default:       o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_ws.sv
// Multicycle MIPS-subset control unit with memory wait-state handshakes,
// stall, watchdog, sticky traps and a retired-instruction counter.
module mc_control_ws import mc_ctrl_pkg::*; #(
  parameter int unsigned OP_W        = 6,
  parameter int unsigned ALU_SEL_W   = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic           clk,
  input  logic           reset,
  mc_control_ws_if.master bus
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] LIMIT = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e           r_state;
  logic [TW-1:0]    r_wait;
  logic [CNT_W-1:0] r_count;
  logic             r_illegal;
  logic             r_timeout;

  logic [ALU_SEL_W-1:0] w_fn_alu;
  logic                 w_fn_illegal;
  logic                 w_ready;
  logic                 w_waiting;
  logic                 w_expire;
  logic                 w_go;

  logic                 w_imem_req, w_dmem_req, w_pcwrite, w_pcwcond, w_irwrite;
  logic                 w_dmemwrite, w_regwrite, w_srca, w_retire;
  logic [1:0]           w_mtr, w_srcb, w_pcsrc;
  logic [ALU_SEL_W-1:0] w_alusel;

  mc_alu_decode #(.OP_W(OP_W), .ALU_SEL_W(ALU_SEL_W)) u_alu_decode (
    .i_funct   (bus.funct),
    .o_alu_sel (w_fn_alu),
    .o_illegal (w_fn_illegal)
  );

  assign w_go      = !bus.stall;
  assign w_ready   = (r_state == S_FETCH) ? bus.imem_ready : bus.dmem_ready;
  assign w_waiting = is_wait_state(r_state) && !w_ready;
  assign w_expire  = (MEM_TIMEOUT != 0) && w_waiting && (r_wait == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_count   <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_retire) r_count <= r_count + 1'b1;
      if (w_go) begin
        if (w_waiting) begin
          if (w_expire) begin
            r_state   <= S_TRAP;
            r_timeout <= 1'b1;
            r_wait    <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end else begin
          r_wait <= '0;
          case (r_state)
            S_FETCH:  r_state <= S_DECODE;
            S_DECODE: begin
              case (bus.opcode)
                OP_W'(OP_R): begin
                  if (w_fn_illegal) begin
                    r_state   <= S_TRAP;
                    r_illegal <= 1'b1;
                  end else begin
                    r_state <= S_EXEC_R;
                  end
                end
                OP_W'(OP_LW), OP_W'(OP_SW): r_state <= S_MEMADR;
                OP_W'(OP_ADDI):             r_state <= S_EXEC_I;
                OP_W'(OP_BEQ):              r_state <= S_BRANCH;
                OP_W'(OP_J):                r_state <= S_JUMP;
                default: begin
                  r_state   <= S_TRAP;
                  r_illegal <= 1'b1;
                end
              endcase
            end
            S_MEMADR: r_state <= (bus.opcode == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  r_state <= S_WB_MEM;
            S_EXEC_R: r_state <= S_WB_R;
            S_EXEC_I: r_state <= S_WB_I;
            S_MEMWR, S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: r_state <= S_FETCH;
            S_TRAP:   r_state <= S_TRAP;
            default:  r_state <= S_TRAP;
          endcase
        end
      end
    end
  end

  // Controls decode from state; strobes also need ready (wait states) and no stall.
  always_comb begin
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_pcwrite   = 1'b0;
    w_pcwcond   = 1'b0;
    w_irwrite   = 1'b0;
    w_dmemwrite = 1'b0;
    w_regwrite  = 1'b0;
    w_srca      = 1'b0;
    w_retire    = 1'b0;
    w_mtr       = MTR_ALU_RD;
    w_srcb      = SRCB_REG;
    w_pcsrc     = PCS_ALU;
    w_alusel    = '0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          w_imem_req = 1'b1;
          w_srcb     = SRCB_FOUR;
          w_alusel   = ALU_SEL_W'(ALU_ADD);
          w_irwrite  = bus.imem_ready && w_go;
          w_pcwrite  = bus.imem_ready && w_go;
        end
        S_DECODE: begin
          w_srcb   = SRCB_BOFF;
          w_alusel = ALU_SEL_W'(ALU_ADD);
        end
        S_MEMADR, S_EXEC_I: begin
          w_srca   = 1'b1;
          w_srcb   = SRCB_IMM;
          w_alusel = ALU_SEL_W'(ALU_ADD);
        end
        S_MEMRD: w_dmem_req = 1'b1;
        S_MEMWR: begin
          w_dmem_req  = 1'b1;
          w_dmemwrite = bus.dmem_ready && w_go;
          w_retire    = bus.dmem_ready && w_go;
        end
        S_WB_MEM: begin
          w_regwrite = w_go;
          w_mtr      = MTR_MDR_RT;
          w_retire   = w_go;
        end
        S_EXEC_R: begin
          w_srca   = 1'b1;
          w_alusel = w_fn_alu;
        end
        S_WB_R: begin
          w_regwrite = w_go;
          w_retire   = w_go;
        end
        S_WB_I: begin
          w_regwrite = w_go;
          w_mtr      = MTR_ALU_RT;
          w_retire   = w_go;
        end
        S_BRANCH: begin
          w_srca    = 1'b1;
          w_alusel  = ALU_SEL_W'(ALU_SUB);
          w_pcwcond = w_go;
          w_pcsrc   = PCS_ALUOUT;
          w_retire  = w_go;
        end
        S_JUMP: begin
          w_pcwrite = w_go;
          w_pcsrc   = PCS_JUMP;
          w_retire  = w_go;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req    = w_imem_req;
  assign bus.dmem_req    = w_dmem_req;
  assign bus.PCWrite     = w_pcwrite;
  assign bus.PCWriteCond = w_pcwcond;
  assign bus.IRWrite     = w_irwrite;
  assign bus.DMEMWrite   = w_dmemwrite;
  assign bus.RegWrite    = w_regwrite;
  assign bus.ALUSrcA     = w_srca;
  assign bus.RegReadSel  = 1'b0;
  assign bus.MemtoReg    = w_mtr;
  assign bus.ALUSrcB     = w_srcb;
  assign bus.PCSource    = w_pcsrc;
  assign bus.ALUSel      = w_alusel;
  assign bus.state_dbg   = r_state;
  assign bus.retire      = w_retire;
  assign bus.instr_count = r_count;
  assign bus.illegal     = r_illegal;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_mc_control_ws.sv
// Bench for mc_control_ws: expected state sequences are built per instruction
// from opcode and wait counts; expected controls come from a per-state table.
module tb_mc_control_ws;

  typedef struct packed {
    logic       imem_req, dmem_req, PCWrite, PCWriteCond, IRWrite, DMEMWrite;
    logic       RegWrite, ALUSrcA, RegReadSel;
    logic [1:0] MemtoReg, ALUSrcB, PCSource;
    logic [3:0] ALUSel;
    logic       retire;
  } ctl_t;

  typedef struct {
    int st;
    bit ir;
    bit dr;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_n2 = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       stall = 1'b1;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  bit         sel = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_cnt = '0;

  int          o_st;
  ctl_t        o_ctl;
  logic [31:0] o_cnt;
  logic        o_ill, o_to;
  ctl_t        ctl1, ctl2;
  step_t       seq[$];

  logic [5:0] legal_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] ops[6]      = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  logic [5:0] t_op[8]     = '{6'b000000, 6'b100011, 6'b000100, 6'b000010,
                              6'b001000, 6'b101011, 6'b000000, 6'b000000};
  logic [5:0] t_fn[8]     = '{6'b100000, 6'b000000, 6'b111111, 6'b000000,
                              6'b000000, 6'b000000, 6'b101010, 6'b100010};
  int         t_iw[8]     = '{0, 3, 0, 0, 1, 2, 0, 1};
  int         t_dw[8]     = '{0, 2, 0, 0, 0, 3, 0, 0};

  mc_control_ws_if #(.OP_W(6), .ALU_SEL_W(4), .CNT_W(32)) bus1 ();
  mc_control_ws_if #(.OP_W(6), .ALU_SEL_W(4), .CNT_W(32)) bus2 ();

  mc_control_ws #(.OP_W(6), .ALU_SEL_W(4), .MEM_TIMEOUT(15), .CNT_W(32)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1));
  mc_control_ws #(.OP_W(6), .ALU_SEL_W(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut2 (
    .clk(clk), .reset(rst_n2), .bus(bus2));

  assign bus1.opcode = opcode;      assign bus2.opcode = opcode;
  assign bus1.funct = funct;        assign bus2.funct = funct;
  assign bus1.stall = stall;        assign bus2.stall = stall;
  assign bus1.imem_ready = imem_ready; assign bus2.imem_ready = imem_ready;
  assign bus1.dmem_ready = dmem_ready; assign bus2.dmem_ready = dmem_ready;

  assign ctl1 = {bus1.imem_req, bus1.dmem_req, bus1.PCWrite, bus1.PCWriteCond, bus1.IRWrite,
                 bus1.DMEMWrite, bus1.RegWrite, bus1.ALUSrcA, bus1.RegReadSel, bus1.MemtoReg,
                 bus1.ALUSrcB, bus1.PCSource, bus1.ALUSel, bus1.retire};
  assign ctl2 = {bus2.imem_req, bus2.dmem_req, bus2.PCWrite, bus2.PCWriteCond, bus2.IRWrite,
                 bus2.DMEMWrite, bus2.RegWrite, bus2.ALUSrcA, bus2.RegReadSel, bus2.MemtoReg,
                 bus2.ALUSrcB, bus2.PCSource, bus2.ALUSel, bus2.retire};

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_of(logic [5:0] fn);
    case (fn)
      6'b100000: return 4'd2;
      6'b100010: return 4'd6;
      6'b100100: return 4'd0;
      6'b100101: return 4'd1;
      6'b101010: return 4'd7;
      default:   return 4'd0;
    endcase
  endfunction

  // Control bus each state should present, given the ready/stall inputs seen in that cycle.
  function automatic ctl_t exp_ctrl(int st, bit ir, bit dr, bit stl, logic [5:0] fn);
    ctl_t c = '0;
    bit   go = !stl;
    case (st)
      0:  begin c.imem_req = 1; c.ALUSrcB = 2'b01; c.ALUSel = 4'd2;
                c.IRWrite = ir && go; c.PCWrite = ir && go; end
      1:  begin c.ALUSrcB = 2'b11; c.ALUSel = 4'd2; end
      2, 8: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUSel = 4'd2; end
      3:  c.dmem_req = 1;
      4:  begin c.dmem_req = 1; c.DMEMWrite = dr && go; c.retire = dr && go; end
      5:  begin c.RegWrite = go; c.MemtoReg = 2'b01; c.retire = go; end
      6:  begin c.ALUSrcA = 1; c.ALUSel = alu_of(fn); end
      7:  begin c.RegWrite = go; c.retire = go; end
      9:  begin c.RegWrite = go; c.MemtoReg = 2'b10; c.retire = go; end
      10: begin c.ALUSrcA = 1; c.ALUSel = 4'd6; c.PCWriteCond = go; c.PCSource = 2'b01; c.retire = go; end
      11: begin c.PCWrite = go; c.PCSource = 2'b10; c.retire = go; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Per-cycle expected states of one legal instruction, with the ready levels to drive.
  function automatic void build_seq(logic [5:0] op, int iw, int dw);
    seq.delete();
    for (int i = 0; i < iw; i++) seq.push_back('{0, 1'b0, rb()});
    seq.push_back('{0, 1'b1, rb()});
    seq.push_back('{1, rb(), rb()});
    case (op)
      6'b000000: begin seq.push_back('{6, rb(), rb()}); seq.push_back('{7, rb(), rb()}); end
      6'b100011, 6'b101011: begin
        int ms = (op == 6'b100011) ? 3 : 4;
        seq.push_back('{2, rb(), rb()});
        for (int i = 0; i < dw; i++) seq.push_back('{ms, rb(), 1'b0});
        seq.push_back('{ms, rb(), 1'b1});
        if (ms == 3) seq.push_back('{5, rb(), rb()});
      end
      6'b000100: seq.push_back('{10, rb(), rb()});
      6'b000010: seq.push_back('{11, rb(), rb()});
      6'b001000: begin seq.push_back('{8, rb(), rb()}); seq.push_back('{9, rb(), rb()}); end
      default: ;
    endcase
  endfunction

  task automatic sample();
    o_st  = sel ? int'(bus2.state_dbg) : int'(bus1.state_dbg);
    o_ctl = sel ? ctl2 : ctl1;
    o_cnt = sel ? bus2.instr_count : bus1.instr_count;
    o_ill = sel ? bus2.illegal : bus1.illegal;
    o_to  = sel ? bus2.timeout : bus1.timeout;
  endtask

  task automatic cycle(input bit ir, input bit dr, input bit stl);
    @(negedge clk);
    imem_ready = ir;
    dmem_ready = dr;
    stall = stl;
    #1;
    sample();
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0);
    n_checks++; if (o_st !== 0) $display("FAIL reset_state: got %0d want 0", o_st); else n_pass++;
    n_checks++; if (o_ctl !== '0) $display("FAIL reset_ctl: got %h want 0", o_ctl); else n_pass++;
    n_checks++; if ({o_cnt, o_ill, o_to} !== '0) $display("FAIL reset_regs: cnt %0d ill %b to %b want 0", o_cnt, o_ill, o_to); else n_pass++;
    @(negedge clk); stall = 1'b1; rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_st !== 0) $display("FAIL post_reset_state: got %0d want 0", o_st); else n_pass++;
    n_checks++; if (o_ctl !== exp_ctrl(0, 0, 0, 0, funct)) $display("FAIL post_reset_ctl: got %h want %h", o_ctl, exp_ctrl(0, 0, 0, 0, funct)); else n_pass++;
  endtask

  task automatic test_instr_table();
    step_t e;
    ctl_t  ex;
    for (int k = 0; k < 8; k++) begin
      opcode = t_op[k];
      funct = t_fn[k];
      build_seq(t_op[k], t_iw[k], t_dw[k]);
      while (seq.size() > 0) begin
        e = seq.pop_front();
        cycle(e.ir, e.dr, 1'b0);
        ex = exp_ctrl(e.st, e.ir, e.dr, 1'b0, funct);
        if (ex.retire) model_cnt++;
        n_checks++; if (o_st !== e.st) $display("FAIL table%0d_state: got %0d want %0d", k, o_st, e.st); else n_pass++;
        n_checks++; if (o_ctl !== ex) $display("FAIL table%0d_ctl st %0d: got %h want %h", k, e.st, o_ctl, ex); else n_pass++;
      end
      @(posedge clk); #1; sample();
      n_checks++; if (o_cnt !== model_cnt || o_st !== 0) $display("FAIL table%0d_end: cnt %0d st %0d want cnt %0d st 0", k, o_cnt, o_st, model_cnt); else n_pass++;
    end
  endtask

  task automatic test_trap();
    opcode = 6'b111111;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_st !== 1) $display("FAIL trap_decode: got %0d want 1", o_st); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      cycle(rb(), rb(), 1'b0);
      n_checks++; if (o_st !== 15 || o_ctl !== '0 || o_ill !== 1'b1 || o_to !== 1'b0)
        $display("FAIL trap_hold%0d: st %0d ctl %h ill %b to %b want 15 0 1 0", i, o_st, o_ctl, o_ill, o_to); else n_pass++;
    end
    @(negedge clk); #2; rst_n = 1'b0; #1; sample();
    model_cnt = '0;
    n_checks++; if (o_st !== 0 || o_ctl !== '0 || o_ill !== 1'b0 || o_cnt !== '0)
      $display("FAIL trap_reset: st %0d ctl %h ill %b cnt %0d want all 0", o_st, o_ctl, o_ill, o_cnt); else n_pass++;
    @(negedge clk); stall = 1'b1; rst_n = 1'b1;
    opcode = 6'b000000; funct = 6'b000000;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_st !== 15 || o_ill !== 1'b1) $display("FAIL trap_badfunct: st %0d ill %b want 15 1", o_st, o_ill); else n_pass++;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); stall = 1'b1; rst_n = 1'b1;
  endtask

  task automatic test_stall();
    opcode = 6'b101011;
    funct = 6'($urandom);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_st !== 2) $display("FAIL stall_memadr: got %0d want 2", o_st); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      n_checks++; if (o_st !== 4 || o_ctl !== exp_ctrl(4, 0, 1, 1, funct))
        $display("FAIL stall_hold%0d: st %0d ctl %h want 4 %h", i, o_st, o_ctl, exp_ctrl(4, 0, 1, 1, funct)); else n_pass++;
    end
    cycle(1'b0, 1'b1, 1'b0);
    model_cnt++;
    n_checks++; if (o_st !== 4 || o_ctl !== exp_ctrl(4, 0, 1, 0, funct))
      $display("FAIL stall_release: st %0d ctl %h want 4 %h", o_st, o_ctl, exp_ctrl(4, 0, 1, 0, funct)); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_st !== 0 || o_cnt !== model_cnt) $display("FAIL stall_done: st %0d cnt %0d want 0 %0d", o_st, o_cnt, model_cnt); else n_pass++;
  endtask

  task automatic test_random();
    step_t e;
    ctl_t  ex;
    bit    stl, ir, dr;
    for (int k = 0; k < 40; k++) begin
      opcode = ops[$urandom_range(0, 5)];
      funct = (opcode == 6'b000000) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
      build_seq(opcode, $urandom_range(0, 4), $urandom_range(0, 4));
      while (seq.size() > 0) begin
        e = seq[0];
        stl = ($urandom_range(0, 99) < 20);
        ir = stl ? rb() : e.ir;
        dr = stl ? rb() : e.dr;
        cycle(ir, dr, stl);
        ex = exp_ctrl(e.st, ir, dr, stl, funct);
        n_checks++; if (o_st !== e.st) $display("FAIL rand%0d_state: got %0d want %0d", k, o_st, e.st); else n_pass++;
        n_checks++; if (o_ctl !== ex) $display("FAIL rand%0d_ctl st %0d stall %b: got %h want %h", k, e.st, stl, o_ctl, ex); else n_pass++;
        if (!stl) begin
          if (ex.retire) model_cnt++;
          void'(seq.pop_front());
        end
      end
      @(posedge clk); #1; sample();
      n_checks++; if (o_cnt !== model_cnt || o_ill !== 1'b0 || o_to !== 1'b0)
        $display("FAIL rand%0d_end: cnt %0d ill %b to %b want %0d 0 0", k, o_cnt, o_ill, o_to, model_cnt); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    @(negedge clk); rst_n = 1'b0; sel = 1'b1; stall = 1'b1; rst_n2 = 1'b1;
    opcode = 6'b101011;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_checks++; if (o_st !== 4 || o_ctl !== exp_ctrl(4, 0, 0, 0, funct))
        $display("FAIL tmo_wait%0d: st %0d ctl %h want 4 %h", i, o_st, o_ctl, exp_ctrl(4, 0, 0, 0, funct)); else n_pass++;
    end
    cycle(1'b0, 1'b1, 1'b0);
    n_checks++; if (o_st !== 15 || o_to !== 1'b1 || o_ill !== 1'b0 || o_ctl !== '0 || o_cnt !== '0)
      $display("FAIL tmo_trap: st %0d to %b ill %b ctl %h cnt %0d want 15 1 0 0 0", o_st, o_to, o_ill, o_ctl, o_cnt); else n_pass++;
    @(negedge clk); rst_n2 = 1'b0;
    @(negedge clk); stall = 1'b1; rst_n2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(i == 3, 1'b0, 1'b0);
      n_checks++; if (o_st !== 0) $display("FAIL tmo_fetch%0d: got %0d want 0", i, o_st); else n_pass++;
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, i == 3, 1'b0);
      n_checks++; if (o_st !== 4 || o_ctl !== exp_ctrl(4, 0, i == 3, 0, funct))
        $display("FAIL tmo_edge%0d: st %0d ctl %h want 4 %h", i, o_st, o_ctl, exp_ctrl(4, 0, i == 3, 0, funct)); else n_pass++;
    end
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_st !== 0 || o_to !== 1'b0 || o_cnt !== 32'd1)
      $display("FAIL tmo_notrap: st %0d to %b cnt %0d want 0 0 1", o_st, o_to, o_cnt); else n_pass++;
    @(negedge clk); rst_n2 = 1'b0; sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_instr_table();
    test_trap();
    test_stall();
    test_random();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
